twiddle_gen: RTL and testbench
==============================

# twiddle_gen

Parametrised, pipelined twiddle-factor generator for the radix-2 FFT/IFFT datapath. It returns W = cos(2πk/N) ± j·sin(2πk/N) in signed fixed point for any N = 2^LOG2N. It stores only a quarter-wave cosine table and derives the other three quadrants by index folding and negation. It accepts either external index requests through a valid/ready handshake or an internal per-stage sweep that feeds the butterfly sequencer directly.

## Interface
- LOG2N, default 5: log2 of transform size N; legal range 3..12.
- W, default 36: output word width, signed two's complement.
- FRAC, default 32: fraction bits; 1.0 = 2^FRAC; W ≥ FRAC+2 is required (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inverse  in  1  1: IFFT, w_i = +sin; 0: FFT, w_i = −sin; sampled with each accepted request.
- in_valid  in  1  external request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_index  in  LOG2N  k, 0..N−1.
- start  in  1  one-cycle pulse; begins a stage sweep.
- stage  in  clog2(LOG2N)  sweep stage s, 0..LOG2N−1; sampled with start.
- busy  out  1  sweep in progress.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- w_r  out  W  cos term.
- w_i  out  W  signed sin term.
- out_index  out  LOG2N  k of the current result.
- out_last  out  1  final result of a sweep.

## Operation
- Table T(m) = round-half-away(cos(2πm/N)·2^FRAC), m = 0..N/4 (N/4+1 entries), built at elaboration.
- Fold: q = k[LOG2N-1:LOG2N-2], r = k mod N/4. The pipeline computes cos/sin (sign flips w_i to −sin when inverse=0):
  - q0: cos = T(r), sin = T(N/4−r).
  - q1: cos = −T(N/4−r), sin = T(r).
  - q2: cos = −T(r), sin = −T(N/4−r).
  - q3: cos = T(N/4−r), sin = −T(r).
- Negation is exact two's complement at W bits. −1.0 is representable and no saturation is needed.
- Sweep: start while idle latches s and sets busy. The generator issues j = 0..N/2−1 with k = (j mod 2^(LOG2N−1−s))·2^s, one per cycle whenever stage 1 can accept. out_last is set on the result for j = N/2−1. busy clears in the cycle that result is accepted at the output.
- While busy: in_ready = 0 and external requests are ignored. A start pulse is ignored. inverse is still sampled per issued index.
- If start and in_valid are both high while idle: start wins, and the external request is not accepted (in_ready = 0 that cycle).

## Timing
- Two-stage elastic pipeline. S1 registers the fold decode (q, r, N/4−r, inverse, index, last). S2 registers the ROM read plus negation.
- Each stage loads when it is empty or its downstream advances. in_ready = !s1_valid | s1_advance.
- Latency: a request accepted in cycle t appears on out_valid at t+2 with out_ready held high.
- Throughput: one result per cycle, with no bubbles under continuous out_ready.
- When out_valid=1 & out_ready=0, w_r, w_i, out_index and out_last hold stable. No request is lost or duplicated.
- Reset (asynchronous, any time, including mid-sweep) clears out_valid, busy, out_last, all stage valids, w_r, w_i and out_index to 0. in_ready reads 1 in the first cycle after deassertion.

## Structure
- twiddle_pkg holds the constant function computing T(m), the quadrant encoding constants, and a width-check function for W/FRAC.
- Sub-module twiddle_qrom is a combinational dual-read quarter-wave table (addresses r and N/4−r), parametrised by LOG2N, W and FRAC.
- The sweep counter, fold logic and elastic pipeline live in twiddle_gen.

## Test plan
- LOG2N=5, W=36, FRAC=32, inverse=1, k=4 → w_r=w_i=0x0B504F334; k=8 → w_r=0x000000000, w_i=0x100000000; each appears 2 cycles after acceptance.
- inverse=0, k=4 → w_i=0xF4AFB0CCC. k=12, inverse=1 → w_r=0xF4AFB0CCC, w_i=0x0B504F334. k=16 → w_r=0xF00000000, w_i=0.
- Back-to-back k=0..31 with out_ready=1 → 32 consecutive valid outputs. Every result satisfies w_r(k)=w_r(32−k), and w_i is antisymmetric.
- Stall: out_ready low for 3 cycles mid-stream → outputs held stable, in_ready drops once both stages are full, and no index is lost or duplicated.
- Sweep s=1 → out_index sequence 0,2,…,14,0,2,…,14 (16 results), out_last on the 16th only, busy low after its acceptance. s=4 → 16 results all k=0. External in_valid during the sweep is not accepted.
- rst_n asserted mid-sweep → out_valid and busy are 0 immediately. A new start after release runs a full sweep from j=0.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared constants and elaboration-time helpers for the twiddle-factor generator.
package twiddle_pkg;

  // Quadrant encoding: the two MSBs of the index k.
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_ISSUE = 2'd1,
    SW_DRAIN = 2'd2
  } sweep_state_e;

  // T(m) = round-half-away(cos(2*pi*m/N) * 2^frac), N = 2^log2n.
  // Only ever evaluated as a constant while building the table.
  function automatic logic [63:0] cos_fixed(int log2n, int frac, int m);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(1 << log2n);
    v   = $cos(ang) * (2.0 ** frac);
    if (v >= 0.0) return 64'(longint'($floor(v + 0.5)));
    else          return 64'(-longint'($floor(-v + 0.5)));
  endfunction

  // +/-1.0 needs FRAC fraction bits, one integer bit and a sign bit.
  function automatic bit width_ok(int w, int frac);
    return (w >= frac + 2);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Combinational dual-read quarter-wave cosine table, entries T(0)..T(N/4).
// The address space is rounded up to a power of two; unused slots read 0.
module twiddle_qrom #(
  parameter int LOG2N = 5,
  parameter int W     = 36,
  parameter int FRAC  = 32
) (
  input  logic [LOG2N-2:0] addr_a,
  input  logic [LOG2N-2:0] addr_b,
  output logic [W-1:0]     data_a,
  output logic [W-1:0]     data_b
);
  import twiddle_pkg::*;

  localparam int DEPTH = 1 << (LOG2N - 1);
  localparam int QN    = 1 << (LOG2N - 2);

  logic [W-1:0] rom [DEPTH];

  for (genvar m = 0; m < DEPTH; m++) begin : g_rom
    localparam logic [63:0] VAL = (m <= QN) ? cos_fixed(LOG2N, FRAC, m) : 64'd0;
    assign rom[m] = W'(VAL);
  end

  assign data_a = rom[addr_a];
  assign data_b = rom[addr_b];

endmodule

// File: rtl/twiddle_gen.sv
// Pipelined twiddle-factor generator: W = cos(2*pi*k/N) +/- j*sin(2*pi*k/N).
// External index requests or an internal per-stage sweep feed a two-stage
// elastic pipeline: S1 holds the quadrant fold, S2 the table read and negation.
module twiddle_gen #(
  parameter int LOG2N = 5,
  parameter int W     = 36,
  parameter int FRAC  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inverse,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LOG2N-1:0]          in_index,
  input  logic                      start,
  input  logic [$clog2(LOG2N)-1:0]  stage,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              w_r,
  output logic [W-1:0]              w_i,
  output logic [LOG2N-1:0]          out_index,
  output logic                      out_last
);
  import twiddle_pkg::*;

  localparam int SW   = $clog2(LOG2N);
  localparam int AW   = LOG2N - 1;          // table address: 0..N/4 inclusive
  localparam int HALF = 1 << (LOG2N - 1);   // sweep length N/2
  localparam int QN   = 1 << (LOG2N - 2);
  localparam logic [AW-1:0] J_LAST = AW'(HALF - 1);

  if (!width_ok(W, FRAC)) begin : g_bad_width
    $error("twiddle_gen: W must be at least FRAC+2");
  end
  if (LOG2N < 3 || LOG2N > 12) begin : g_bad_log2n
    $error("twiddle_gen: LOG2N must be in 3..12");
  end

  // Sweep sequencer
  sweep_state_e     state, state_nxt;
  logic [AW-1:0]    j_cnt;
  logic [SW-1:0]    s_lat;
  logic [LOG2N-1:0] sweep_mask, sweep_k;

  // S1 (fold) registers
  logic             s1_valid, s1_inv, s1_last;
  logic [1:0]       s1_q;
  logic [AW-1:0]    s1_r, s1_rc;
  logic [LOG2N-1:0] s1_index;

  // Handshake and source selection
  logic             s2_load, s1_adv, s1_load, idle;
  logic             ext_fire, sweep_fire;
  logic [LOG2N-1:0] src_k;
  logic [AW-1:0]    src_r;

  // S2 datapath
  logic [W-1:0]     t_a, t_b, cos_v, sin_v, wi_v;

  assign idle       = (state == SW_IDLE);
  assign s2_load    = !out_valid | out_ready;
  assign s1_adv     = s1_valid & s2_load;
  assign s1_load    = !s1_valid | s1_adv;
  // start wins over a simultaneous external request; sweeps lock out requests.
  assign in_ready   = idle & !start & s1_load;
  assign ext_fire   = in_valid & in_ready;
  assign sweep_fire = (state == SW_ISSUE) & s1_load;

  // k = (j mod 2^(LOG2N-1-s)) * 2^s
  assign sweep_mask = LOG2N'((HALF >> s_lat) - 1);
  assign sweep_k    = (LOG2N'(j_cnt) & sweep_mask) << s_lat;
  assign src_k      = sweep_fire ? sweep_k : in_index;
  assign src_r      = AW'(src_k[LOG2N-3:0]);

  // Sweep state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SW_IDLE;
    else        state <= state_nxt;
  end

  // Sweep next-state: issue N/2 indices, then wait for the last one to leave.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      SW_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SW_ISSUE;
      end
      SW_ISSUE: if (sweep_fire && j_cnt == J_LAST) state_nxt = SW_DRAIN;
      SW_DRAIN: if (out_valid && out_ready && out_last) state_nxt = SW_IDLE;
      default:  state_nxt = SW_IDLE;
    endcase
  end

  // Sweep counter and latched stage; out-of-range stages clamp to the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_cnt <= '0;
      s_lat <= '0;
    end else if (idle && start) begin
      j_cnt <= '0;
      s_lat <= (int'(stage) > LOG2N - 1) ? SW'(LOG2N - 1) : stage;
    end else if (sweep_fire) begin
      j_cnt <= j_cnt + 1'b1;
    end
  end

  // S1: register quadrant, folded offset r, its complement N/4-r and tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_r     <= '0;
      s1_rc    <= '0;
      s1_inv   <= 1'b0;
      s1_index <= '0;
      s1_last  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= ext_fire | sweep_fire;
      if (ext_fire || sweep_fire) begin
        s1_q     <= src_k[LOG2N-1:LOG2N-2];
        s1_r     <= src_r;
        s1_rc    <= AW'(QN) - src_r;
        s1_inv   <= inverse;
        s1_index <= src_k;
        s1_last  <= sweep_fire & (j_cnt == J_LAST);
      end
    end
  end

  twiddle_qrom #(.LOG2N(LOG2N), .W(W), .FRAC(FRAC)) u_qrom (
    .addr_a (s1_r),
    .addr_b (s1_rc),
    .data_a (t_a),
    .data_b (t_b)
  );

  // Quadrant unfold: pick T(r) / T(N/4-r) and negate per quadrant, then
  // flip the sine for the forward transform.
  always_comb begin
    cos_v = t_a;
    sin_v = t_b;
    case (s1_q)
      QUAD_0: begin cos_v = t_a;  sin_v = t_b;  end
      QUAD_1: begin cos_v = -t_b; sin_v = t_a;  end
      QUAD_2: begin cos_v = -t_a; sin_v = -t_b; end
      QUAD_3: begin cos_v = t_b;  sin_v = -t_a; end
      default: ;
    endcase
    wi_v = s1_inv ? sin_v : -sin_v;
  end

  // S2: output register; holds while stalled by out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      w_r       <= '0;
      w_i       <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid & s1_last;
      if (s1_valid) begin
        w_r       <= cos_v;
        w_i       <= wi_v;
        out_index <= s1_index;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen: directed test-plan points plus
// randomized traffic scored against a floating-point reference model.
module tb_twiddle_gen;
  localparam int LOG2N = 5;
  localparam int W     = 36;
  localparam int FRAC  = 32;
  localparam int N     = 1 << LOG2N;
  localparam int SW    = $clog2(LOG2N);
  localparam real PI   = 3.14159265358979323846;

  logic             clk, rst_n, inverse, in_valid, in_ready, start, busy;
  logic             out_valid, out_ready, out_last;
  logic [LOG2N-1:0] in_index, out_index;
  logic [SW-1:0]    stage;
  logic [W-1:0]     w_r, w_i;

  typedef struct {
    logic [LOG2N-1:0] k;
    logic [W-1:0]     wr;
    logic [W-1:0]     wi;
    logic             last;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t exq[$];
  int   n_chk, n_fail, cyc;
  bit   mdl_busy, front_seen, lat_mode;

  twiddle_gen #(.LOG2N(LOG2N), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .inverse(inverse), .in_valid(in_valid),
    .in_ready(in_ready), .in_index(in_index), .start(start), .stage(stage),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .w_r(w_r),
    .w_i(w_i), .out_index(out_index), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Fixed-point value of a real, rounded half away from zero, W-bit two's complement.
  function automatic logic [W-1:0] fx(real v);
    real a;
    a = v * (2.0 ** FRAC);
    if (a >= 0.0) return W'(longint'($floor(a + 0.5)));
    else          return W'(-longint'($floor(-a + 0.5)));
  endfunction

  function automatic exp_t mk(int k, bit inv, bit last, int acc, bit lat);
    exp_t e;
    real  ang;
    ang    = 2.0 * PI * real'(k) / real'(N);
    e.k    = LOG2N'(k);
    e.wr   = fx($cos(ang));
    e.wi   = inv ? fx($sin(ang)) : fx(-$sin(ang));
    e.last = last;
    e.acc  = acc;
    e.lat  = lat;
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    bit was_busy;
    bit e_rdy;
    int kk;
    if (!rst_n) begin
      exq.delete();
      mdl_busy   = 1'b0;
      front_seen = 1'b0;
    end else begin
      was_busy = mdl_busy;
      e_rdy    = !mdl_busy && !start && (exq.size() < 2 || out_ready);
      chk("busy", 64'(busy), 64'(mdl_busy));
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      if (out_valid) begin
        if (exq.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          if (!front_seen && exq[0].lat) chk("latency", 64'(cyc - exq[0].acc), 64'd2);
          front_seen = 1'b1;
          chk("out_index", 64'(out_index), 64'(exq[0].k));
          chk("w_r", 64'(w_r), 64'(exq[0].wr));
          chk("w_i", 64'(w_i), 64'(exq[0].wi));
          chk("out_last", 64'(out_last), 64'(exq[0].last));
          if (out_ready) begin
            if (exq[0].last) mdl_busy = 1'b0;
            void'(exq.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) exq.push_back(mk(int'(in_index), inverse, 1'b0, cyc, lat_mode));
      if (start && !was_busy) begin
        mdl_busy = 1'b1;
        for (int j = 0; j < N / 2; j++) begin
          kk = (j % (1 << (LOG2N - 1 - int'(stage)))) * (1 << int'(stage));
          exq.push_back(mk(kk, inverse, j == N / 2 - 1, cyc, 1'b0));
        end
      end
    end
  end

  task automatic drain(input int max);
    int i;
    i = 0;
    while ((exq.size() != 0 || mdl_busy) && i < max) begin
      @(posedge clk); #1;
      i++;
    end
    if (exq.size() != 0 || mdl_busy)
      chk("drain_timeout", 64'(exq.size()) + 64'(mdl_busy), 64'd0);
  endtask

  task automatic single(input int k, input bit inv, input logic [W-1:0] ewr, input logic [W-1:0] ewi);
    @(posedge clk); #1;
    in_valid = 1'b1; in_index = LOG2N'(k); inverse = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dir_valid", 64'(out_valid), 64'd1);
    chk("dir_w_r", 64'(w_r), 64'(ewr));
    chk("dir_w_i", 64'(w_i), 64'(ewi));
    drain(10);
  endtask

  task automatic sweep(input int s, input bit inv, input bit rnd);
    @(posedge clk); #1;
    start = 1'b1; stage = SW'(s); inverse = inv;
    in_valid = 1'b1; in_index = LOG2N'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && (mdl_busy || exq.size() != 0); i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_index  = LOG2N'($urandom);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nv, first_v, last_v;
    n_chk = 0; n_fail = 0; lat_mode = 1'b0;
    rst_n = 1'b0; inverse = 1'b0; in_valid = 1'b0; in_index = '0;
    start = 1'b0; stage = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_w_r", 64'(w_r), 64'd0);
    chk("rst_w_i", 64'(w_i), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Test-plan points with exact latency
    lat_mode = 1'b1;
    single(4,  1'b1, 36'h0B504F334, 36'h0B504F334);
    single(8,  1'b1, 36'h000000000, 36'h100000000);
    single(4,  1'b0, 36'h0B504F334, 36'hF4AFB0CCC);
    single(12, 1'b1, 36'hF4AFB0CCC, 36'h0B504F334);
    single(16, 1'b1, 36'hF00000000, 36'h000000000);

    // Back-to-back k = 0..31: 32 consecutive results
    nv = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 32); in_index = LOG2N'(i); inverse = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
    end
    chk("b2b_count", 64'(nv), 64'd32);
    chk("b2b_contig", 64'(last_v - first_v + 1), 64'd32);
    lat_mode = 1'b0;
    in_valid = 1'b0;
    drain(10);

    // Three-cycle stall mid-stream
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      in_valid  = (i < 10);
      in_index  = LOG2N'($urandom);
      inverse   = 1'($urandom_range(0, 1));
      out_ready = !(i >= 4 && i < 7);
      @(negedge clk);
      if (i == 6) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(10);

    // Random external traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_index  = LOG2N'($urandom);
      inverse   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(20);

    // Sweeps
    sweep(1, 1'b1, 1'b0);
    sweep(4, 1'b0, 1'b0);
    sweep(0, 1'b1, 1'b1);
    sweep(3, 1'b0, 1'b1);
    sweep(2, 1'b1, 1'b1);

    // Reset in the middle of a sweep, then a full sweep afterwards
    @(posedge clk); #1;
    start = 1'b1; stage = SW'(2); inverse = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sweep(2, 1'b0, 1'b0);
    sweep(1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
